uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one simplex UART transmitter between `N_REQ` byte sources. It accepts per-requester request/data, selects one winner per frame, and presents the winner's byte with a one-cycle transmit-enable pulse. It then holds off further grants for the full frame time plus a configurable inter-frame gap. It sits between the byte-producing blocks and the transmitter's `i_DATA_IN` and `i_TX_ENABLE` inputs.

---
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ byte sources,
// granting one frame at a time and holding off for frame time plus an inter-frame gap.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter int FRAME_BITS   = 10,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic [N_REQ-1:0]         i_REQ,
    input  logic [8*N_REQ-1:0]       i_DATA,
    output logic [N_REQ-1:0]         o_GRANT,
    output logic [$clog2(N_REQ)-1:0] o_GRANT_IDX,
    output logic [7:0]               o_TX_DATA,
    output logic                     o_TX_ENABLE,
    output logic                     o_BUSY,
    output logic [1:0]               o_STATE
);

    localparam int IW = $clog2(N_REQ);
    localparam int F  = FRAME_BITS * CLKS_PER_BIT;
    localparam int CW = $clog2(F + GAP_CYCLES + 1);
    localparam logic [CW-1:0] FRAME_LOAD = CW'(F - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;

    logic [IW-1:0]    win;
    logic [IW-1:0]    scan_idx;
    logic [N_REQ-1:0] win_onehot;
    logic [7:0]       win_data;

    // Scan downward in distance so the closest requester after the pointer is the last to write win.
    always_comb begin
        win      = ptr_q;
        scan_idx = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            scan_idx = IW'((int'(ptr_q) + off) % N_REQ);
            if (i_REQ[scan_idx]) begin
                win = scan_idx;
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        win_data   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win == IW'(k)) begin
                win_onehot[k] = 1'b1;
                win_data      = i_DATA[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = '0;
        en_d    = 1'b0;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (|i_REQ) begin
                    state_d = S_LOAD;
                    grant_d = win_onehot;
                    en_d    = 1'b1;
                    idx_d   = win;
                    data_d  = win_data;
                    ptr_d   = win;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
                cnt_d   = FRAME_LOAD;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= IW'(N_REQ - 1);
            grant_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign o_GRANT     = grant_q;
    assign o_GRANT_IDX = idx_q;
    assign o_TX_DATA   = data_q;
    assign o_TX_ENABLE = en_q;
    assign o_BUSY      = busy_q;
    assign o_STATE     = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: default-parameter instance plus a
// GAP_CYCLES=0 / CLKS_PER_BIT=4 instance, with a grant scoreboard.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;
    logic [3:0]  grant;
    logic [1:0]  gidx;
    logic [7:0]  txd;
    logic        txen, busy;
    logic [1:0]  state;

    logic [3:0]  req2 = '0;
    logic [31:0] data2 = '0;
    logic [3:0]  grant2;
    logic [1:0]  gidx2;
    logic [7:0]  txd2;
    logic        txen2, busy2;
    logic [1:0]  state2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int grant_lat = 0;
    int gcyc = 0;

    // {grant index, byte} expected for each grant of the default instance
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter dut (
        .i_CLK(clk), .i_RST(rst), .i_REQ(req), .i_DATA(data),
        .o_GRANT(grant), .o_GRANT_IDX(gidx), .o_TX_DATA(txd),
        .o_TX_ENABLE(txen), .o_BUSY(busy), .o_STATE(state)
    );

    uart_tx_arbiter #(.N_REQ(4), .CLKS_PER_BIT(4), .FRAME_BITS(10), .GAP_CYCLES(0)) dut2 (
        .i_CLK(clk), .i_RST(rst), .i_REQ(req2), .i_DATA(data2),
        .o_GRANT(grant2), .o_GRANT_IDX(gidx2), .o_TX_DATA(txd2),
        .o_TX_ENABLE(txen2), .o_BUSY(busy2), .o_STATE(state2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed=timeout expected=event", tag);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req = '0;
        req2 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_grant(input string tag, input int budget);
        int n;
        logic [9:0] e;
        logic [3:0] oh;
        @(negedge clk);
        n = 1;
        while (grant == 4'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (grant == 4'b0) begin
            timeout_fail(tag);
        end else begin
            grant_lat = n;
            gcyc = cyc;
            if (exp_q.size() == 0) begin
                timeout_fail({tag, "_unexpected"});
            end else begin
                e = exp_q.pop_front();
                oh = 4'b0001 << e[9:8];
                chk({tag, "_grant"}, 32'(grant), 32'(oh));
                chk({tag, "_idx"}, 32'(gidx), 32'(e[9:8]));
                chk({tag, "_data"}, 32'(txd), 32'(e[7:0]));
                chk({tag, "_en"}, 32'(txen), 32'd1);
                chk({tag, "_busy"}, 32'(busy), 32'd1);
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || state != 2'd0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy || state != 2'd0) timeout_fail(tag);
    endtask

    initial begin
        int n_busy, n_en, n_gnt, prev, m, c1;

        // reset values
        do_reset();
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_idx", 32'(gidx), 32'd0);
        chk("rst_data", 32'(txd), 32'd0);
        chk("rst_en", 32'(txen), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(state), 32'd0);

        // single request from requester 2
        @(posedge clk); #1;
        data = 32'h0;
        data[23:16] = 8'h2A;
        req = 4'b0100;
        exp_q.push_back({2'd2, 8'h2A});
        wait_grant("single", 5);
        chk("single_latency", 32'(grant_lat), 32'd2);
        n_busy = 0; n_en = 0; n_gnt = 0;
        while (busy && n_busy < 100) begin
            n_busy++;
            n_en += int'(txen);
            n_gnt += int'(grant != 4'b0);
            @(posedge clk); #1 req = 4'b0;
            @(negedge clk);
        end
        chk("single_busy_len", 32'(n_busy), 32'd12);
        chk("single_en_pulses", 32'(n_en), 32'd1);
        chk("single_grant_pulses", 32'(n_gnt), 32'd1);
        chk("single_hold_data", 32'(txd), 32'h2A);
        chk("single_hold_idx", 32'(gidx), 32'd2);

        // all four held continuously, round robin from reset
        do_reset();
        data = 32'h13121110;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({2'(i % 4), 8'(8'h10 + (i % 4))});
        end
        @(posedge clk); #1 req = 4'b1111;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_grant("rr", 20);
            if (i > 0) chk("rr_spacing", 32'(gcyc - prev), 32'd13);
            prev = gcyc;
        end
        @(posedge clk); #1 req = 4'b0;
        wait_idle("rr_idle");

        // fairness: after grant to 2, 0101 -> 0
        data = $urandom();
        exp_q.push_back({2'd2, data[23:16]});
        exp_q.push_back({2'd0, data[7:0]});
        @(posedge clk); #1 req = 4'b0100;
        wait_grant("fair_a1", 5);
        @(posedge clk); #1 req = 4'b0101;
        wait_grant("fair_a2", 20);
        @(posedge clk); #1 req = 4'b0;
        wait_idle("fair_a_idle");

        // fairness: after grant to 2, 0110 -> 1 (scan wraps past 3)
        data = $urandom();
        exp_q.push_back({2'd2, data[23:16]});
        exp_q.push_back({2'd1, data[15:8]});
        @(posedge clk); #1 req = 4'b0100;
        wait_grant("fair_b1", 5);
        @(posedge clk); #1 req = 4'b0110;
        wait_grant("fair_b2", 20);
        @(posedge clk); #1 req = 4'b0;
        wait_idle("fair_b_idle");

        // requester 3 pulses its request entirely inside WAIT
        data = $urandom();
        exp_q.push_back({2'd1, data[15:8]});
        @(posedge clk); #1 req = 4'b0010;
        wait_grant("mid", 5);
        n_busy = 0; n_gnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) req = 4'b0;
            if (k == 3) req = 4'b1000;
            if (k == 6) req = 4'b0;
            @(negedge clk);
            n_busy += int'(busy);
            n_gnt += int'(grant != 4'b0);
        end
        chk("mid_busy_len", 32'(n_busy), 32'd11);
        chk("mid_no_grant", 32'(n_gnt), 32'd0);
        chk("mid_state_idle", 32'(state), 32'd0);

        // reset during WAIT, then 1111 goes to requester 0
        data = $urandom();
        exp_q.push_back({2'd1, data[15:8]});
        @(posedge clk); #1 req = 4'b0010;
        wait_grant("rstw", 5);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        req = 4'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstw_grant", 32'(grant), 32'd0);
        chk("rstw_idx", 32'(gidx), 32'd0);
        chk("rstw_data", 32'(txd), 32'd0);
        chk("rstw_en", 32'(txen), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_state", 32'(state), 32'd0);
        exp_q.push_back({2'd0, data[7:0]});
        @(posedge clk); #1;
        rst = 1'b0;
        req = 4'b1111;
        wait_grant("rstw_rr", 5);
        chk("rstw_latency", 32'(grant_lat), 32'd2);
        @(posedge clk); #1 req = 4'b0;
        wait_idle("rstw_idle");

        // GAP_CYCLES=0, CLKS_PER_BIT=4 instance: busy 41, grants 42 apart
        data2 = $urandom();
        @(posedge clk); #1 req2 = 4'b0001;
        m = 0;
        @(negedge clk);
        while (grant2 == 4'b0 && m < 5) begin
            @(negedge clk);
            m++;
        end
        if (grant2 == 4'b0) timeout_fail("corner_grant1");
        chk("corner_grant1", 32'(grant2), 32'b0001);
        chk("corner_data1", 32'(txd2), 32'(data2[7:0]));
        chk("corner_en1", 32'(txen2), 32'd1);
        c1 = cyc;
        n_busy = 0;
        while (busy2 && n_busy < 100) begin
            n_busy++;
            @(negedge clk);
        end
        chk("corner_busy_len", 32'(n_busy), 32'd41);
        m = 0;
        while (grant2 == 4'b0 && m < 10) begin
            @(negedge clk);
            m++;
        end
        if (grant2 == 4'b0) timeout_fail("corner_grant2");
        chk("corner_spacing", 32'(cyc - c1), 32'd42);
        chk("corner_idx2", 32'(gidx2), 32'd0);
        @(posedge clk); #1 req2 = 4'b0;

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
